// File: rtl/jt6295_enc.sv
// OKI/MSM6295-compatible 4-bit ADPCM encoder: signed 12-bit PCM in, packed nibble bytes out.
// Serial successive-approximation quantiser, 5 cycles per sample; the predictor mirrors the decoder.
module jt6295_enc #(
  parameter bit         CLR_ON_LAST = 1'b1,
  parameter logic [3:0] PAD_NIBBLE  = 4'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [11:0] pcm_in,
  input  logic               pcm_valid,
  output logic               pcm_ready,
  input  logic               pcm_last,
  output logic [7:0]         byte_out,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               byte_last,
  output logic               busy
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] B2   = 3'd1;
  localparam logic [2:0] B1   = 3'd2;
  localparam logic [2:0] B0   = 3'd3;
  localparam logic [2:0] UPD  = 3'd4;

  function automatic logic [10:0] step_lut(input logic [5:0] i);
    case (i)
      6'd0:  step_lut = 11'd16;   6'd1:  step_lut = 11'd17;   6'd2:  step_lut = 11'd19;
      6'd3:  step_lut = 11'd21;   6'd4:  step_lut = 11'd23;   6'd5:  step_lut = 11'd25;
      6'd6:  step_lut = 11'd28;   6'd7:  step_lut = 11'd31;   6'd8:  step_lut = 11'd34;
      6'd9:  step_lut = 11'd37;   6'd10: step_lut = 11'd41;   6'd11: step_lut = 11'd45;
      6'd12: step_lut = 11'd50;   6'd13: step_lut = 11'd55;   6'd14: step_lut = 11'd60;
      6'd15: step_lut = 11'd66;   6'd16: step_lut = 11'd73;   6'd17: step_lut = 11'd80;
      6'd18: step_lut = 11'd88;   6'd19: step_lut = 11'd97;   6'd20: step_lut = 11'd107;
      6'd21: step_lut = 11'd118;  6'd22: step_lut = 11'd130;  6'd23: step_lut = 11'd143;
      6'd24: step_lut = 11'd157;  6'd25: step_lut = 11'd173;  6'd26: step_lut = 11'd190;
      6'd27: step_lut = 11'd209;  6'd28: step_lut = 11'd230;  6'd29: step_lut = 11'd253;
      6'd30: step_lut = 11'd279;  6'd31: step_lut = 11'd307;  6'd32: step_lut = 11'd337;
      6'd33: step_lut = 11'd371;  6'd34: step_lut = 11'd408;  6'd35: step_lut = 11'd449;
      6'd36: step_lut = 11'd494;  6'd37: step_lut = 11'd544;  6'd38: step_lut = 11'd598;
      6'd39: step_lut = 11'd658;  6'd40: step_lut = 11'd724;  6'd41: step_lut = 11'd796;
      6'd42: step_lut = 11'd876;  6'd43: step_lut = 11'd963;  6'd44: step_lut = 11'd1060;
      6'd45: step_lut = 11'd1166; 6'd46: step_lut = 11'd1282; 6'd47: step_lut = 11'd1411;
      default: step_lut = 11'd1552;
    endcase
  endfunction

  logic [2:0]         state_reg;
  logic signed [11:0] pred_reg;
  logic [5:0]         idx_reg;
  logic               half_reg;
  logic signed [12:0] diff_reg;
  logic               last_reg;
  logic [3:0]         code_reg;
  logic [11:0]        d_reg;
  logic [10:0]        st_reg;
  logic [7:0]         byte_out_reg;
  logic               byte_valid_reg;
  logic               byte_last_reg;

  logic [11:0]        st_now;
  logic [11:0]        abs_diff;
  logic [11:0]        st12;
  logic [11:0]        st_half;
  logic [11:0]        st_quart;
  logic [11:0]        st_eighth;
  logic [11:0]        delta;
  logic signed [12:0] pred_ext;
  logic signed [12:0] delta_ext;
  logic signed [12:0] pred_sum;
  logic signed [11:0] pred_next;
  logic signed [6:0]  idx_adj;
  logic signed [6:0]  idx_sum;
  logic [5:0]         idx_next;
  logic               transfer;

  assign pcm_ready  = (state_reg == IDLE) && !byte_valid_reg;
  assign transfer   = pcm_valid && pcm_ready;
  assign byte_out   = byte_out_reg;
  assign byte_valid = byte_valid_reg;
  assign byte_last  = byte_last_reg;
  assign busy       = (state_reg != IDLE) || byte_valid_reg;

  always_comb begin
    st_now    = {1'b0, step_lut(idx_reg)};
    abs_diff  = diff_reg[12] ? 12'(-diff_reg) : diff_reg[11:0];
    st12      = {1'b0, st_reg};
    st_half   = st12 >> 1;
    st_quart  = st12 >> 2;
    st_eighth = st12 >> 3;
    // Reconstruction exactly as the decoder sees it, not the encoder's residual.
    delta     = st_eighth
              + (code_reg[2] ? st12     : 12'd0)
              + (code_reg[1] ? st_half  : 12'd0)
              + (code_reg[0] ? st_quart : 12'd0);
    pred_ext  = {pred_reg[11], pred_reg};
    delta_ext = {1'b0, delta};
    pred_sum  = code_reg[3] ? (pred_ext - delta_ext) : (pred_ext + delta_ext);
    if (pred_sum > 13'sd2047)
      pred_next = 12'h7FF;
    else if (pred_sum < -13'sd2048)
      pred_next = 12'h800;
    else
      pred_next = pred_sum[11:0];

    case (code_reg[2:0])
      3'd4:    idx_adj = 7'sd2;
      3'd5:    idx_adj = 7'sd4;
      3'd6:    idx_adj = 7'sd6;
      3'd7:    idx_adj = 7'sd8;
      default: idx_adj = -7'sd1;
    endcase
    idx_sum = $signed({1'b0, idx_reg}) + idx_adj;
    if (idx_sum < 7'sd0)
      idx_next = 6'd0;
    else if (idx_sum > 7'sd48)
      idx_next = 6'd48;
    else
      idx_next = idx_sum[5:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      pred_reg       <= '0;
      idx_reg        <= '0;
      half_reg       <= 1'b0;
      diff_reg       <= '0;
      last_reg       <= 1'b0;
      code_reg       <= '0;
      d_reg          <= '0;
      st_reg         <= '0;
      byte_out_reg   <= '0;
      byte_valid_reg <= 1'b0;
      byte_last_reg  <= 1'b0;
    end else begin
      if (byte_valid_reg && byte_ready)
        byte_valid_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (transfer) begin
            diff_reg  <= $signed({pcm_in[11], pcm_in}) - pred_ext;
            last_reg  <= pcm_last;
            state_reg <= B2;
          end
        end
        B2: begin
          st_reg <= st_now[10:0];
          if (abs_diff >= st_now) begin
            code_reg <= {diff_reg[12], 3'b100};
            d_reg    <= abs_diff - st_now;
          end else begin
            code_reg <= {diff_reg[12], 3'b000};
            d_reg    <= abs_diff;
          end
          state_reg <= B1;
        end
        B1: begin
          if (d_reg >= st_half) begin
            code_reg[1] <= 1'b1;
            d_reg       <= d_reg - st_half;
          end
          state_reg <= B0;
        end
        B0: begin
          if (d_reg >= st_quart)
            code_reg[0] <= 1'b1;
          state_reg <= UPD;
        end
        UPD: begin
          pred_reg <= pred_next;
          idx_reg  <= idx_next;
          if (half_reg) begin
            byte_out_reg[3:0] <= code_reg;
            byte_valid_reg    <= 1'b1;
            byte_last_reg     <= last_reg;
            half_reg          <= 1'b0;
          end else if (last_reg) begin
            // Phrase ends on a high nibble: pad without touching the predictor.
            byte_out_reg   <= {code_reg, PAD_NIBBLE};
            byte_valid_reg <= 1'b1;
            byte_last_reg  <= 1'b1;
          end else begin
            byte_out_reg[7:4] <= code_reg;
            half_reg          <= 1'b1;
          end
          if (CLR_ON_LAST && last_reg) begin
            pred_reg <= '0;
            idx_reg  <= '0;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt6295_enc.sv
// Directed bench for jt6295_enc: hand-computed bytes, saturation runs and a sine loop-back
// through an integer OKI decoder model.
module tb_jt6295_enc;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [11:0] pcm_in;
  logic               pcm_valid;
  logic               pcm_ready;
  logic               pcm_last;
  logic [7:0]         byte_out;
  logic               byte_valid;
  logic               byte_ready;
  logic               byte_last;
  logic               busy;

  int total = 0;
  int bad   = 0;
  logic [8:0] rxq[$];
  int step_tab[49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,
                       88,97,107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,449,494,544,
                       598,658,724,796,876,963,1060,1166,1282,1411,1552};
  int adj_tab[8] = '{-1,-1,-1,-1,2,4,6,8};

  always #5 clk = ~clk;

  jt6295_enc #(.CLR_ON_LAST(1'b1), .PAD_NIBBLE(4'h0)) dut (
    .clk(clk), .rst(rst), .pcm_in(pcm_in), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready),
    .pcm_last(pcm_last), .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_last(byte_last), .busy(busy)
  );

  always @(posedge clk) begin
    if (!rst && byte_valid && byte_ready) begin
      rxq.push_back({byte_last, byte_out});
      $display("byte %02h last=%0d", byte_out, byte_last);
    end
  end

  function automatic int m_code(int s, int pred, int idx);
    int diff, d, st, c;
    diff = s - pred;
    c    = (diff < 0) ? 8 : 0;
    d    = (diff < 0) ? -diff : diff;
    st   = step_tab[idx];
    if (d >= st) begin c += 4; d -= st; end
    if (d >= st / 2) begin c += 2; d -= st / 2; end
    if (d >= st / 4) c += 1;
    return c;
  endfunction

  function automatic int m_pred(int pred, int idx, int c);
    int st, dl, p;
    st = step_tab[idx];
    dl = st / 8;
    if ((c & 4) != 0) dl += st;
    if ((c & 2) != 0) dl += st / 2;
    if ((c & 1) != 0) dl += st / 4;
    p = ((c & 8) != 0) ? pred - dl : pred + dl;
    if (p > 2047) p = 2047;
    if (p < -2048) p = -2048;
    return p;
  endfunction

  function automatic int m_idx(int idx, int c);
    int i;
    i = idx + adj_tab[c & 7];
    if (i < 0) i = 0;
    if (i > 48) i = 48;
    return i;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic signed [11:0] s, input logic l);
    int n = 0;
    while (!pcm_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!pcm_ready) check("send_timeout", {31'b0, pcm_ready}, 32'd1);
    pcm_in    = s;
    pcm_last  = l;
    pcm_valid = 1'b1;
    @(negedge clk);
    pcm_valid = 1'b0;
    pcm_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst       = 1'b1;
    pcm_valid = 1'b0;
    pcm_last  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rxq.delete();
  endtask

  task automatic expect_byte(input string tag, input logic [8:0] exp);
    logic [8:0] got;
    got = 9'bx;
    if (rxq.size() > 0) got = rxq.pop_front();
    check(tag, {23'b0, got}, {23'b0, exp});
  endtask

  task automatic run_const(input int s, input string tag);
    int mp = 0;
    int mi = 0;
    int c;
    logic [7:0] eb;
    logic [8:0] expq[$];
    eb = '0;
    do_reset;
    for (int k = 0; k < 200; k++) begin
      c  = m_code(s, mp, mi);
      mp = m_pred(mp, mi, c);
      mi = m_idx(mi, c);
      if (k % 2 == 0) eb[7:4] = 4'(c);
      else begin
        eb[3:0] = 4'(c);
        expq.push_back({1'b0, eb});
      end
      send(12'(s), 1'b0);
    end
    drain(tag);
    check({tag, "_count"}, 32'(rxq.size()), 32'd100);
    for (int k = 0; k < expq.size(); k++) expect_byte(tag, expq[k]);
  endtask

  initial begin
    int n;
    logic ok;
    int mp, mi, c, dp, di, k, s;
    int expp[$];
    logic [8:0] b;
    real ph;

    rst = 1'b1; pcm_in = '0; pcm_valid = 1'b0; pcm_last = 1'b0; byte_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_byte_out", {24'b0, byte_out}, 32'h0);
    check("rst_byte_valid", {31'b0, byte_valid}, 32'd0);
    check("rst_byte_last", {31'b0, byte_last}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_pcm_ready", {31'b0, pcm_ready}, 32'd1);

    // 0,0 -> nibbles 0 then 8; byte_valid exactly at t+5 of the second sample
    send(12'sd0, 1'b0);
    send(12'sd0, 1'b0);
    repeat (3) @(negedge clk);
    check("lat_before", {31'b0, byte_valid}, 32'd0);
    @(negedge clk);
    check("lat_valid", {31'b0, byte_valid}, 32'd1);
    check("lat_byte", {24'b0, byte_out}, 32'h08);
    @(negedge clk);
    check("lat_drop", {31'b0, byte_valid}, 32'd0);
    expect_byte("zero_pair", 9'h008);
    check("zero_pair_once", 32'(rxq.size()), 32'd0);

    // 2047 -> code 7, pred 30, idx 8; then 70 with STEP 34 -> code 4
    do_reset;
    send(12'sd2047, 1'b0);
    send(12'sd70, 1'b0);
    drain("step34");
    expect_byte("step34", 9'h074);

    do_reset;
    send(12'sd2047, 1'b0);
    send(12'sd2047, 1'b0);
    drain("max_pair");
    expect_byte("max_pair", 9'h077);

    // backpressure
    do_reset;
    byte_ready = 1'b0;
    send(12'sd0, 1'b0);
    send(12'sd0, 1'b0);
    n = 0;
    while (!byte_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", {31'b0, byte_valid}, 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(byte_out == 8'h08 && byte_last == 1'b0 && byte_valid == 1'b1 &&
            pcm_ready == 1'b0 && busy == 1'b1)) ok = 1'b0;
    end
    check("bp_hold", {31'b0, ok}, 32'd1);
    check("bp_no_hs", 32'(rxq.size()), 32'd0);
    byte_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {31'b0, byte_valid}, 32'd0);
    check("bp_ready", {31'b0, pcm_ready}, 32'd1);
    expect_byte("bp_byte", 9'h008);
    check("bp_once", 32'(rxq.size()), 32'd0);

    // phrase -100,0,100(last): F3 then 70 with pad and last, then cleared predictor
    do_reset;
    send(-12'sd100, 1'b0);
    send(12'sd0, 1'b0);
    send(12'sd100, 1'b1);
    drain("phrase");
    expect_byte("phrase_b1", 9'h0F3);
    expect_byte("phrase_b2", 9'h170);
    send(12'sd0, 1'b0);
    send(12'sd0, 1'b0);
    drain("after_last");
    expect_byte("after_last", 9'h008);

    run_const(2047, "sat_pos");
    run_const(-2048, "sat_neg");

    // 1 kHz sine at 8 kHz, decoded back and compared with the model predictor
    do_reset;
    mp = 0; mi = 0;
    for (int i = 0; i < 1000; i++) begin
      ph = 2.0 * 3.14159265358979 * real'(i) / 8.0;
      s  = $rtoi(2000.0 * $sin(ph));
      c  = m_code(s, mp, mi);
      mp = m_pred(mp, mi, c);
      mi = m_idx(mi, c);
      expp.push_back(mp);
      send(12'(s), 1'b0);
    end
    drain("sine");
    dp = 0; di = 0; k = 0;
    while (rxq.size() > 0) begin
      b = rxq.pop_front();
      for (int h = 0; h < 2; h++) begin
        c  = (h == 0) ? int'(b[7:4]) : int'(b[3:0]);
        dp = m_pred(dp, di, c);
        di = m_idx(di, c);
        if (k < expp.size()) check("sine_pred", 32'(dp), 32'(expp[k]));
        k++;
      end
    end
    check("sine_count", 32'(k), 32'd1000);

    // reset while in B1 drops the half-built byte
    do_reset;
    send(12'sd2047, 1'b0);
    send(12'sd1000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", {31'b0, byte_valid}, 32'd0);
    check("midrst_ready", {31'b0, pcm_ready}, 32'd1);
    send(12'sd0, 1'b0);
    send(12'sd0, 1'b0);
    drain("midrst");
    expect_byte("midrst_byte", 9'h008);
    check("midrst_once", 32'(rxq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
